// File: rtl/buzzer_beep.sv
// ---------------------------------------------------------------------------
// buzzer_beep
//   Output stage for the washer panel buzzer. Turns one-cycle requests into
//   square-wave beep patterns:
//     - key_beep  : one short beep (SHORT_TICKS cycles of tone)
//     - done_beep : DONE_BEEPS long beeps (LONG_TICKS each) separated by
//                   GAP_TICKS silent cycles
//   Ports:
//     clock     in   system clock, rising edge
//     reset_n   in   asynchronous active-low reset
//     key_beep  in   1-cycle request for a short beep
//     done_beep in   1-cycle request for the long-beep pattern
//     buzz      out  square wave to the buzzer pad, 0 when silent
//     busy      out  1 while a pattern is playing (TONE or GAP)
// ---------------------------------------------------------------------------
module buzzer_beep #(
   parameter int unsigned CNT_W       = 24,
   parameter int unsigned HALF_PERIOD = 12500,
   parameter int unsigned SHORT_TICKS = 2500000,
   parameter int unsigned LONG_TICKS  = 12500000,
   parameter int unsigned GAP_TICKS   = 6250000,
   parameter int unsigned DONE_BEEPS  = 3
) (
   input  logic clock,
   input  logic reset_n,
   input  logic key_beep,
   input  logic done_beep,
   output logic buzz,
   output logic busy
);

   localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF_PERIOD - 1);
   localparam logic [CNT_W-1:0] SHORT_M1 = CNT_W'(SHORT_TICKS - 1);
   localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(GAP_TICKS - 1);
   localparam logic [2:0]       NBEEPS   = 3'(DONE_BEEPS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_TONE,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic             buzz_q, buzz_d;
   logic             busy_q, busy_d;
   logic             pend_q, pend_d;   // done_beep queued behind a short beep
   logic             long_q, long_d;   // current pattern is the long pattern
   logic [CNT_W-1:0] div_q, div_d;     // half-period divider
   logic [CNT_W-1:0] dur_q, dur_d;     // tone / gap duration counter
   logic [CNT_W-1:0] last_q, last_d;   // final dur value of a tone (len-1)
   logic [2:0]       left_q, left_d;   // tones remaining incl. current

   logic             pend_req;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         buzz_q  <= 1'b0;
         busy_q  <= 1'b0;
         pend_q  <= 1'b0;
         long_q  <= 1'b0;
         div_q   <= '0;
         dur_q   <= '0;
         last_q  <= '0;
         left_q  <= '0;
      end else begin
         state_q <= state_d;
         buzz_q  <= buzz_d;
         busy_q  <= busy_d;
         pend_q  <= pend_d;
         long_q  <= long_d;
         div_q   <= div_d;
         dur_q   <= dur_d;
         last_q  <= last_d;
         left_q  <= left_d;
      end
   end

   always_comb begin
      state_d = state_q;
      buzz_d  = buzz_q;
      pend_d  = pend_q;
      long_d  = long_q;
      div_d   = div_q;
      dur_d   = dur_q;
      last_d  = last_q;
      left_d  = left_q;
      // A done request while playing is only remembered if the long
      // pattern is not already the one playing.
      pend_req = done_beep && !long_q;

      unique case (state_q)
         S_IDLE: begin
            pend_d = 1'b0;
            if (done_beep || key_beep) begin
               state_d = S_TONE;
               buzz_d  = 1'b1;
               div_d   = '0;
               dur_d   = '0;
               if (done_beep) begin
                  last_d = LONG_M1;
                  left_d = NBEEPS;
                  long_d = 1'b1;
               end else begin
                  last_d = SHORT_M1;
                  left_d = 3'd1;
                  long_d = 1'b0;
               end
            end
         end

         S_TONE: begin
            if (pend_req) pend_d = 1'b1;
            dur_d = dur_q + 1'b1;
            if (div_q == HALF_M1) begin
               buzz_d = ~buzz_q;
               div_d  = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
            // End of tone overrides any toggle so buzz drops on this edge.
            if (dur_q == last_q) begin
               buzz_d = 1'b0;
               dur_d  = '0;
               div_d  = '0;
               if (left_q > 3'd1) begin
                  left_d  = left_q - 3'd1;
                  state_d = S_GAP;
               end else if (pend_q || pend_req) begin
                  // A request arriving on the very last tone cycle is
                  // promoted directly rather than stranded in IDLE.
                  pend_d  = 1'b0;
                  last_d  = LONG_M1;
                  left_d  = NBEEPS;
                  long_d  = 1'b1;
                  state_d = S_GAP;
               end else begin
                  long_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end

         S_GAP: begin
            if (pend_req) pend_d = 1'b1;
            buzz_d = 1'b0;
            dur_d  = dur_q + 1'b1;
            if (dur_q == GAP_M1) begin
               state_d = S_TONE;
               buzz_d  = 1'b1;
               div_d   = '0;
               dur_d   = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
            buzz_d  = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign buzz = buzz_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_buzzer_beep.sv
// ---------------------------------------------------------------------------
// tb_buzzer_beep
//   Self-checking bench for buzzer_beep with small timing parameters.
//   A pattern-level reference model appends the expected {buzz,busy}
//   samples of each accepted beep pattern to a queue; every clock the DUT
//   outputs are compared against the next queued sample (silence when empty).
// ---------------------------------------------------------------------------
module tb_buzzer_beep;

   localparam int unsigned HALF  = 2;
   localparam int unsigned SHORT = 8;
   localparam int unsigned LONG  = 16;
   localparam int unsigned GAP   = 4;
   localparam int unsigned NB    = 3;

   logic clock = 1'b0;
   logic reset_n;
   logic key_beep;
   logic done_beep;
   logic buzz;
   logic busy;

   int checks   = 0;
   int failures = 0;

   // Model state: expected {buzz,busy} per cycle after the current one.
   bit [1:0] exp_q[$];
   bit       m_busy = 1'b0;
   bit       m_long = 1'b0;
   bit       m_pend = 1'b0;

   buzzer_beep #(
      .CNT_W      (8),
      .HALF_PERIOD(HALF),
      .SHORT_TICKS(SHORT),
      .LONG_TICKS (LONG),
      .GAP_TICKS  (GAP),
      .DONE_BEEPS (NB)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .key_beep (key_beep),
      .done_beep(done_beep),
      .buzz     (buzz),
      .busy     (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic push_tone(input int unsigned len);
      for (int unsigned i = 0; i < len; i++)
         exp_q.push_back({((i / HALF) % 2 == 0), 1'b1});
   endtask

   task automatic push_gap();
      for (int unsigned i = 0; i < GAP; i++) exp_q.push_back(2'b01);
   endtask

   task automatic push_long();
      for (int unsigned b = 0; b < NB; b++) begin
         push_tone(LONG);
         if (b < NB - 1) push_gap();
      end
   endtask

   // One clock: drive requests, apply them to the model at the sampling
   // edge, then compare the registered outputs just after that edge.
   task automatic step(input bit k, input bit d);
      bit [1:0] e;
      @(negedge clock);
      key_beep  = k;
      done_beep = d;
      @(posedge clock);
      if (!m_busy) begin
         if (d) begin
            push_long();
            m_long = 1'b1;
         end else if (k) begin
            push_tone(SHORT);
         end
      end else if (d && !m_long && !m_pend) begin
         push_gap();
         push_long();
         m_pend = 1'b1;
         m_long = 1'b1;
      end
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
      m_busy = e[0];
      if (!m_busy) begin
         m_long = 1'b0;
         m_pend = 1'b0;
      end
      check("buzz", int'(buzz), int'(e[1]));
      check("busy", int'(busy), int'(e[0]));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   // Asynchronous reset between edges; outputs must clear immediately.
   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_buzz", int'(buzz), 0);
      check("rst_busy", int'(busy), 0);
      exp_q.delete();
      m_busy = 1'b0;
      m_long = 1'b0;
      m_pend = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b0;
      key_beep  = 1'b0;
      done_beep = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("reset_buzz", int'(buzz), 0);
      check("reset_busy", int'(busy), 0);
      @(negedge clock);
      reset_n = 1'b1;

      idle(3);
      // short beep
      step(1'b1, 1'b0); idle(12);
      // long pattern
      step(1'b0, 1'b1); idle(60);
      // simultaneous requests: long only
      step(1'b1, 1'b1); idle(60);
      // done during short beep: short, gap, long pattern
      step(1'b1, 1'b0); idle(2); step(1'b0, 1'b1); idle(75);
      // key during long pattern is ignored
      step(1'b0, 1'b1); idle(10); step(1'b1, 1'b0); idle(60);
      // repeated done during short does not stack
      step(1'b1, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b1); idle(80);
      // reset mid-tone with a pending done, then quiet afterwards
      step(1'b1, 1'b0); idle(1); step(1'b0, 1'b1); idle(1);
      do_reset();
      idle(20);

      // randomized requests with occasional resets
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
         if ($urandom_range(0, 399) == 0) do_reset();
      end
      idle(80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
